// File: rtl/c_fifo_pop_scheduler.sv
// Pop-side scheduler for a bank of c_fifos: round-robin grant, packet lock, credit gating.
// Define C_FIFO_POP_SCHEDULER_CREDIT_BYPASS_EN to let a same-cycle credit_return enable a pop at zero credits.
module c_fifo_pop_scheduler #(
   parameter  int num_queues   = 4,
   parameter  int num_credits  = 8,
   parameter  int stall_limit  = 16,
   localparam int credit_width = $clog2(num_credits + 1),
   localparam int stall_width  = $clog2(stall_limit + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [num_queues-1:0]   empty,
   input  logic [num_queues-1:0]   tail,
   input  logic                    credit_return,
   output logic [num_queues-1:0]   pop,
   output logic [credit_width-1:0] credits,
   output logic                    locked,
   output logic [1:0]              errors
);

   localparam int ptr_width = $clog2(num_queues);
   localparam logic [credit_width-1:0] credits_max = credit_width'(num_credits);
   localparam logic [stall_width-1:0]  stall_max   = stall_width'(stall_limit);

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic [ptr_width-1:0]    rr_ptr_q, rr_ptr_d;
   logic [ptr_width-1:0]    owner_q, owner_d;
   logic [credit_width-1:0] credits_q, credits_d;
   logic [stall_width-1:0]  stall_cnt_q, stall_cnt_d;
   logic [1:0]              errors_q, errors_d;
   logic                    can_send;
   logic                    pop_any;
   logic                    grant_valid;
   logic [ptr_width-1:0]    grant_idx;
   logic [num_queues-1:0]   pop_raw;

   // Pointers wrap explicitly so a non-power-of-2 queue count never yields an out-of-range index.
   function automatic logic [ptr_width-1:0] ptr_inc(input logic [ptr_width-1:0] p);
      if (int'(p) == num_queues - 1) return '0;
      return p + ptr_width'(1);
   endfunction

   // Returns {found, index} of the first requester at or after start, scanning upward with wrap.
   function automatic logic [ptr_width:0] rr_pick(input logic [ptr_width-1:0] start,
                                                  input logic [num_queues-1:0] req);
      logic [ptr_width:0] res;
      int                 idx;
      res = '0;
      for (int k = num_queues - 1; k >= 0; k--) begin
         idx = int'(start) + k;
         if (idx >= num_queues) idx = idx - num_queues;
         if (req[idx]) res = {1'b1, ptr_width'(idx)};
      end
      return res;
   endfunction

`ifdef C_FIFO_POP_SCHEDULER_CREDIT_BYPASS_EN
   assign can_send = (credits_q != '0) | credit_return;
`else
   assign can_send = (credits_q != '0);
`endif

   assign {grant_valid, grant_idx} = rr_pick(rr_ptr_q, ~empty);

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      pop_raw  = '0;
      case (state_q)
         IDLE: begin
            if (can_send && grant_valid) begin
               pop_raw[grant_idx] = 1'b1;
               if (tail[grant_idx]) begin
                  rr_ptr_d = ptr_inc(grant_idx);
               end else begin
                  state_d = LOCKED;
                  owner_d = grant_idx;
               end
            end
         end
         LOCKED: begin
            if (can_send && !empty[owner_q]) begin
               pop_raw[owner_q] = 1'b1;
               if (tail[owner_q]) begin
                  state_d  = IDLE;
                  rr_ptr_d = ptr_inc(owner_q);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign pop_any = |pop_raw;

   always_comb begin
      credits_d   = credits_q;
      errors_d    = errors_q;
      stall_cnt_d = '0;
      if (pop_any && !credit_return) begin
         credits_d = credits_q - credit_width'(1);
      end else if (!pop_any && credit_return) begin
         if (credits_q == credits_max) errors_d[0] = 1'b1;
         else                          credits_d   = credits_q + credit_width'(1);
      end
      if (state_q == LOCKED && empty[owner_q]) begin
         stall_cnt_d = (stall_cnt_q == stall_max) ? stall_cnt_q : stall_cnt_q + stall_width'(1);
      end
      if (stall_cnt_d == stall_max) errors_d[1] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         credits_q   <= credits_max;
         stall_cnt_q <= '0;
         errors_q    <= 2'b00;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         credits_q   <= credits_d;
         stall_cnt_q <= stall_cnt_d;
         errors_q    <= errors_d;
      end
   end

   // The strobe is masked during reset so FIFOs never see a pop while the scheduler is held.
   assign pop     = reset ? pop_raw : '0;
   assign credits = credits_q;
   assign locked  = (state_q == LOCKED);
   assign errors  = errors_q;

endmodule

// File: tb/tb_c_fifo_pop_scheduler.sv
// Vector-table bench for c_fifo_pop_scheduler: round-robin, packet lock, credits, stall, overflow, async reset.
module tb_c_fifo_pop_scheduler;

   localparam int CW = 4;
   localparam int W  = 4 + CW + 1 + 2;

   logic          clk           = 1'b0;
   logic          reset         = 1'b1;
   logic [3:0]    empty         = 4'hF;
   logic [3:0]    tail          = 4'h0;
   logic          credit_return = 1'b0;
   logic [3:0]    pop;
   logic [CW-1:0] credits;
   logic          locked;
   logic [1:0]    errors;

   always #5 clk = ~clk;

   c_fifo_pop_scheduler dut (
      .clk           (clk),
      .reset         (reset),
      .empty         (empty),
      .tail          (tail),
      .credit_return (credit_return),
      .pop           (pop),
      .credits       (credits),
      .locked        (locked),
      .errors        (errors)
   );

   // One cycle of stimulus, the pop expected in that cycle, and the registered outputs after its edge.
   typedef struct {
      logic [3:0]    empty;
      logic [3:0]    tail;
      logic          cr;
      logic [3:0]    pop;
      logic [CW-1:0] credits;
      logic          locked;
      logic [1:0]    errors;
   } vec_t;

   vec_t          vecs[$];
   logic [W-1:0]  exp_q[$];
   int            n_checks = 0;
   int            n_pass   = 0;

   function automatic vec_t mk(input logic [3:0] e, input logic [3:0] t, input logic cr,
                               input logic [3:0] p, input int c, input logic lk, input logic [1:0] er);
      vec_t v;
      v.empty   = e;
      v.tail    = t;
      v.cr      = cr;
      v.pop     = p;
      v.credits = CW'(c);
      v.locked  = lk;
      v.errors  = er;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic do_reset();
      reset         = 1'b0;
      empty         = 4'h0;
      tail          = 4'hF;
      credit_return = 1'b0;
      #2;
      check("reset pop",     32'(pop),     32'(0));
      check("reset credits", 32'(credits), 32'(8));
      check("reset locked",  32'(locked),  32'(0));
      check("reset errors",  32'(errors),  32'(0));
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   // Entered just after a rising edge; leaves just after the edge of the last vector.
   task automatic run_table(input string tag);
      logic [W-1:0] w;
      for (int i = 0; i < vecs.size(); i++) begin
         empty         = vecs[i].empty;
         tail          = vecs[i].tail;
         credit_return = vecs[i].cr;
         exp_q.push_back({vecs[i].pop, vecs[i].credits, vecs[i].locked, vecs[i].errors});
         @(negedge clk);
         w = exp_q.pop_front();
         check($sformatf("%s[%0d] pop", tag, i), 32'(pop), 32'(w[10:7]));
         @(posedge clk);
         #1;
         check($sformatf("%s[%0d] credits", tag, i), 32'(credits), 32'(w[6:3]));
         check($sformatf("%s[%0d] locked", tag, i),  32'(locked),  32'(w[2]));
         check($sformatf("%s[%0d] errors", tag, i),  32'(errors),  32'(w[1:0]));
      end
      vecs.delete();
   endtask

   initial begin
      #1;
      do_reset();

      // Round-robin with every queue busy, single-flit packets, credits replenished each cycle.
      vecs.push_back(mk(4'b0000, 4'b1111, 1'b1, 4'b0001, 8, 1'b0, 2'b00));
      vecs.push_back(mk(4'b0000, 4'b1111, 1'b1, 4'b0010, 8, 1'b0, 2'b00));
      vecs.push_back(mk(4'b0000, 4'b1111, 1'b1, 4'b0100, 8, 1'b0, 2'b00));
      vecs.push_back(mk(4'b0000, 4'b1111, 1'b1, 4'b1000, 8, 1'b0, 2'b00));
      vecs.push_back(mk(4'b0000, 4'b1111, 1'b1, 4'b0001, 8, 1'b0, 2'b00));
      run_table("rr");

      // Queue 0 sends a 3-flit packet while queue 2 waits its turn.
      do_reset();
      vecs.push_back(mk(4'b1010, 4'b0100, 1'b1, 4'b0001, 8, 1'b1, 2'b00));
      vecs.push_back(mk(4'b1010, 4'b0100, 1'b1, 4'b0001, 8, 1'b1, 2'b00));
      vecs.push_back(mk(4'b1010, 4'b0101, 1'b1, 4'b0001, 8, 1'b0, 2'b00));
      vecs.push_back(mk(4'b1010, 4'b0101, 1'b1, 4'b0100, 8, 1'b0, 2'b00));
      vecs.push_back(mk(4'b1010, 4'b0101, 1'b1, 4'b0001, 8, 1'b0, 2'b00));
      run_table("lock");

      // Credit exhaustion, then a single credit returned at zero.
      do_reset();
      for (int i = 0; i < 8; i++)
         vecs.push_back(mk(4'b0000, 4'b1111, 1'b0, 4'(1 << (i % 4)), 7 - i, 1'b0, 2'b00));
      vecs.push_back(mk(4'b0000, 4'b1111, 1'b0, 4'b0000, 0, 1'b0, 2'b00));
`ifdef C_FIFO_POP_SCHEDULER_CREDIT_BYPASS_EN
      vecs.push_back(mk(4'b0000, 4'b1111, 1'b1, 4'b0001, 0, 1'b0, 2'b00));
      vecs.push_back(mk(4'b0000, 4'b1111, 1'b0, 4'b0000, 0, 1'b0, 2'b00));
`else
      vecs.push_back(mk(4'b0000, 4'b1111, 1'b1, 4'b0000, 1, 1'b0, 2'b00));
      vecs.push_back(mk(4'b0000, 4'b1111, 1'b0, 4'b0001, 0, 1'b0, 2'b00));
`endif
      vecs.push_back(mk(4'b0000, 4'b1111, 1'b0, 4'b0000, 0, 1'b0, 2'b00));
      run_table("credit");

      // Lock on queue 1, starve it for the full stall limit, then refill.
      do_reset();
      vecs.push_back(mk(4'b1101, 4'b0000, 1'b0, 4'b0010, 7, 1'b1, 2'b00));
      for (int i = 1; i <= 16; i++)
         vecs.push_back(mk(4'b1111, 4'b0000, 1'b0, 4'b0000, 7, 1'b1, (i == 16) ? 2'b10 : 2'b00));
      vecs.push_back(mk(4'b1101, 4'b0010, 1'b0, 4'b0010, 6, 1'b0, 2'b10));
      vecs.push_back(mk(4'b1111, 4'b0000, 1'b0, 4'b0000, 6, 1'b0, 2'b10));
      run_table("stall");

      // Overflow on a full counter, then move rr_ptr and lock on queue 2.
      do_reset();
      vecs.push_back(mk(4'b1111, 4'b0000, 1'b1, 4'b0000, 8, 1'b0, 2'b01));
      vecs.push_back(mk(4'b1101, 4'b1111, 1'b0, 4'b0010, 7, 1'b0, 2'b01));
      vecs.push_back(mk(4'b1011, 4'b0000, 1'b0, 4'b0100, 6, 1'b1, 2'b01));
      run_table("ovf");

      // Reset mid-packet must act before any clock edge.
      empty = 4'b0000;
      tail  = 4'b1111;
      reset = 1'b0;
      #2;
      check("async pop",     32'(pop),     32'(0));
      check("async locked",  32'(locked),  32'(0));
      check("async credits", 32'(credits), 32'(8));
      check("async errors",  32'(errors),  32'(0));
      @(posedge clk);
      #1;
      reset = 1'b1;
      vecs.push_back(mk(4'b0000, 4'b1111, 1'b0, 4'b0001, 7, 1'b0, 2'b00));
      vecs.push_back(mk(4'b0000, 4'b1111, 1'b0, 4'b0010, 6, 1'b0, 2'b00));
      run_table("restart");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
